hex_triple_driver: RTL
======================

Name: hex_triple_driver

Overview:
- Downstream consumer of the 24-bit Avalon PIO word that software writes for HEX2..HEX0.
- Converts each byte into 7-segment drive for one display, with blank, blink and PWM brightness control.
- Snapshots its inputs only at frame boundaries, so a software write landing mid-frame never produces a partially updated display.
- Sits between the PIO out_port and the board HEX pins.

Parameters:
- PRESCALE, 2500: clk cycles per PWM step; must be >= 1.
- PWM_BITS, 4: PWM counter width. One frame = PRESCALE * 2^PWM_BITS clk cycles.
- BLINK_FRAMES, 390: frames per blink half-period (about 2 Hz at defaults).
- ACTIVE_LOW, 1: 1 means segment on = 0 (DE-series boards); 0 means segment on = 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- digits_in  in  24  byte n (bits 8n+7:8n) drives hexn. Byte format: [3:0] hex digit; [4] blank; [5] blink; [6] full-on, ignores brightness; [7] reserved, ignored.
- brightness  in  PWM_BITS  duty level. 0 = off; all-ones = always on; otherwise on for brightness/2^PWM_BITS of each frame.
- hex0, hex1, hex2  out  7  segments, bit6..bit0 = g..a
- frame_start  out  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- Reset (reset_n asynchronous, active-low; clock clk):
  - prescale counter, pwm_cnt, blink counter and blink_phase all go to 0.
  - Shadow digit registers reset to 0x10 per byte (blanked).
  - Shadow brightness resets to 0.
  - hex0..2 reset to all segments off: 7'h7F if ACTIVE_LOW, else 7'h00.
  - frame_start resets to 0.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - step pulse when the count = PRESCALE-1.
  - pwm_cnt increments on step and wraps from 2^PWM_BITS-1 to 0.
- Frame boundary:
  - A frame boundary is a step with pwm_cnt = all-ones, i.e. the wrap.
  - In that cycle the shadows load digits_in and brightness.
  - frame_start is asserted on the following cycle, the first cycle with pwm_cnt = 0.
  - Inputs changing at any other time have no effect until the next boundary.
  - First boundary after reset occurs PRESCALE * 2^PWM_BITS cycles after reset release.
- Blink:
  - The blink counter increments on each frame boundary.
  - When it reaches BLINK_FRAMES-1 it clears and blink_phase toggles; phase 1 = blinking digits dark.
  - Blink counter and phase are shared by all three digits, so all blinking digits are in phase.
- Per-digit enable:
  - en = !blank && !(blink && blink_phase) && (full_on || duty).
  - duty: brightness == all-ones ? 1 : (pwm_cnt < brightness). brightness 0 therefore always gives duty = 0.
- Decode, standard hex, active-high form:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Output:
  - hexn = en ? decode : 0, then inverted if ACTIVE_LOW.
  - Registered, so outputs reflect shadow/pwm state with 1-cycle latency.
- Simultaneous events: a boundary that both reloads the shadows and toggles blink_phase uses the new values from the next cycle onward; no glitch cycle.
- Mid-operation reset: immediate blank; counters restart from 0.

Optional Feature:
- Macro: HEX_LAMP_TEST_EN.
- Defined:
  - Adds input lamp_test (1 bit), synchronized through 2 flops.
  - While the synchronized lamp_test = 1, hex0..2 = all segments on (7'h00 if ACTIVE_LOW), overriding blank, blink, brightness and frame timing.
  - Output latency is 3 cycles from the lamp_test edge.
  - Counters and shadows keep running, so normal display resumes correctly on release.
- Undefined: port absent; behaviour as above.

Test Plan:
Bench parameters: PRESCALE=2, PWM_BITS=4, BLINK_FRAMES=3, ACTIVE_LOW=1; frame = 32 cycles.
- Reset, then digits_in=24'h000102 with brightness=4'hF → hex0..2=7F until the first frame_start (cycle 32). One cycle later hex2=40, hex1=79, hex0=24, steady thereafter.
- Change digits_in to 24'h0A0B0C at cycle 40, mid-frame → outputs unchanged until the cycle-64 boundary. Afterwards hex2=08, hex1=03, hex0=46.
- brightness=4'h4, digits_in=24'h000008 → hex0 = 00 (on) for pwm_cnt 0..3 (8 cycles) and 7F for pwm_cnt 4..15 (24 cycles) each frame. brightness=0 → hex0 constant 7F.
- Byte 0 = 8'h28 (blink, digit 8) → hex0 on for 3 frames and off for 3 frames (96-cycle half-periods). Byte 1 = 8'h18 → hex1 stays 7F.
- Byte 0 = 8'h45 with brightness=1 → hex0 = 12 (digit 5, full-on) every cycle. Assert reset_n=0 mid-frame → all outputs 7F in the same cycle, counters at 0.
- HEX_LAMP_TEST_EN defined: lamp_test=1 with all digits blanked → hex0..2 = 00 after 3 cycles. Release → back to 7F, with frame_start period still 32 cycles.

Source files
------------

// File: rtl/hex_triple_driver.sv
// Three-digit 7-segment driver with frame-synchronous shadowing, blank/blink and PWM dimming.
// Optional lamp-test input is compiled in when HEX_LAMP_TEST_EN is defined.
module hex_triple_driver #(
  parameter int unsigned PRESCALE     = 2500,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned BLINK_FRAMES = 390,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [23:0]         digits_in,
  input  logic [PWM_BITS-1:0] brightness,
`ifdef HEX_LAMP_TEST_EN
  input  logic                lamp_test,
`endif
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic                frame_start
);

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [SEG_W-1:0]   SEG_DARK   = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [SEG_W-1:0]   SEG_LIT    = ACTIVE_LOW ? 7'h00 : 7'h7F;

  // One byte of digits_in as seen by a single display.
  typedef struct packed {
    logic       rsvd;
    logic       full_on;
    logic       blink;
    logic       blank;
    logic [3:0] value;
  } digit_cfg_t;

  localparam digit_cfg_t DIGIT_RESET = digit_cfg_t'(8'h10);

  logic [PRESC_W-1:0]                   presc_q, presc_d;
  logic [PWM_BITS-1:0]                  pwm_q, pwm_d;
  logic [BLINK_W-1:0]                   blink_cnt_q, blink_cnt_d;
  logic                                 blink_phase_q, blink_phase_d;
  digit_cfg_t [NUM_DIGITS-1:0]          shadow_q, shadow_d;
  logic [PWM_BITS-1:0]                  bright_q, bright_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     hex_q, hex_d;
  logic                                 frame_start_q, frame_start_d;

  logic                                 step;
  logic                                 boundary;
  logic                                 duty;
  logic                                 lamp_on;

  // Standard hex glyphs, active-high, bit6..bit0 = g..a.
  function automatic logic [SEG_W-1:0] decode_hex(input logic [3:0] d);
    logic [SEG_W-1:0] seg;
    case (d)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

`ifdef HEX_LAMP_TEST_EN
  logic lamp_meta_q;
  logic lamp_sync_q;

  // Two-flop synchronizer for the asynchronous lamp-test request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lamp_meta_q <= 1'b0;
      lamp_sync_q <= 1'b0;
    end else begin
      lamp_meta_q <= lamp_test;
      lamp_sync_q <= lamp_meta_q;
    end
  end

  assign lamp_on = lamp_sync_q;
`else
  assign lamp_on = 1'b0;
`endif

  // Timebase: prescaler, PWM step counter and frame boundary detect.
  always_comb begin
    step     = (presc_q == PRESC_LAST);
    boundary = step && (pwm_q == {PWM_BITS{1'b1}});
    presc_d  = step ? '0 : presc_q + PRESC_W'(1);
    pwm_d    = step ? pwm_q + PWM_BITS'(1) : pwm_q;
  end

  // Shadow reload and blink sequencing, both only at the frame boundary.
  always_comb begin
    shadow_d      = shadow_q;
    bright_d      = bright_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_start_d = boundary;
    if (boundary) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_d[i] = digit_cfg_t'(digits_in[8*i +: 8]);
      end
      bright_d = brightness;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Per-digit enable and segment drive; lamp test overrides everything.
  always_comb begin
    duty = (bright_q == {PWM_BITS{1'b1}}) || (pwm_q < bright_q);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic             en;
      logic [SEG_W-1:0] seg;
      en  = !shadow_q[i].blank
            && !(shadow_q[i].blink && blink_phase_q)
            && (shadow_q[i].full_on || duty);
      seg = en ? decode_hex(shadow_q[i].value) : '0;
      hex_d[i] = ACTIVE_LOW ? ~seg : seg;
      if (lamp_on) begin
        hex_d[i] = SEG_LIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shadow_q      <= {NUM_DIGITS{DIGIT_RESET}};
      bright_q      <= '0;
      hex_q         <= {NUM_DIGITS{SEG_DARK}};
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      pwm_q         <= pwm_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      bright_q      <= bright_d;
      hex_q         <= hex_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hex0        = hex_q[0];
  assign hex1        = hex_q[1];
  assign hex2        = hex_q[2];
  assign frame_start = frame_start_q;

endmodule
